// File: rtl/debug_unit.sv
// Board-level debug front end: synchronizes and debounces switches, runs the
// HALT/RUN/STEP clock-enable FSM and muxes CPU debug data onto LEDs/display.
module debug_unit #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned STEP_LEN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        succ,
    input  logic        step,
    input  logic        inc,
    input  logic        dec,
    input  logic        m_rf,
    input  logic [2:0]  sel,
    input  logic [11:0] status,
    input  logic [31:0] m_data,
    input  logic [31:0] rf_data,
    input  logic [31:0] sel_data,
    output logic        cpu_en,
    output logic [15:0] m_rf_addr,
    output logic [2:0]  i_sel,
    output logic [15:0] led,
    output logic [31:0] disp_data
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned SW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    // Bit order: 0 succ, 1 step, 2 inc, 3 dec, 4 m_rf
    logic [4:0]    raw, sync1, sync2, db;
    logic [2:0]    db_d;
    logic [CW-1:0] db_cnt [5];
    logic          succ_db, m_rf_db, step_p, inc_p, dec_p;

    state_t        state;
    logic [SW-1:0] step_cnt;
    logic [4:0]    rf_idx;
    logic [7:0]    mem_idx;

    assign raw = {m_rf, dec, inc, step, succ};

    // A level is accepted once DB_CYCLES consecutive samples differ from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int unsigned i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db[3:1];
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign succ_db = db[0];
    assign m_rf_db = db[4];
    assign step_p  = db[1] & ~db_d[0];
    assign inc_p   = db[2] & ~db_d[1];
    assign dec_p   = db[3] & ~db_d[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HALT;
            step_cnt <= '0;
            cpu_en   <= 1'b0;
        end else begin
            cpu_en <= (state == RUN) || (state == STEP);
            case (state)
                HALT: begin
                    if (succ_db) begin
                        state <= RUN;
                    end else if (step_p) begin
                        state    <= STEP;
                        step_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!succ_db) state <= HALT;
                end
                STEP: begin
                    if (step_cnt == SW'(STEP_LEN - 1)) state <= HALT;
                    else                              step_cnt <= step_cnt + 1'b1;
                end
                default: state <= HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_idx  <= '0;
            mem_idx <= '0;
        end else if (inc_p != dec_p) begin
            if (m_rf_db) mem_idx <= inc_p ? mem_idx + 8'd1 : mem_idx - 8'd1;
            else         rf_idx  <= inc_p ? rf_idx + 5'd1  : rf_idx - 5'd1;
        end
    end

    always_comb begin
        m_rf_addr = m_rf_db ? {6'b0, mem_idx, 2'b00} : {11'b0, rf_idx};
        i_sel     = sel;
        if (sel == 3'd0) begin
            disp_data = m_rf_db ? m_data : rf_data;
            led       = m_rf_addr;
        end else begin
            disp_data = sel_data;
            led       = {4'b0, status};
        end
    end

endmodule
